// File: rtl/macc_frame_pkg.sv
// Shared types and helpers for the MACC frame controller: FSM state encoding,
// result-discard tracking sizes and a pointer-width helper.
package macc_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Depth of the in-flight new_acc tracking queue (must exceed MACC result latency).
    localparam int DQ_DEPTH = 8;
    localparam int DQ_IW    = 3;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/macc_frame_ctrl_fifo.sv
// First-word-fall-through result FIFO carrying {dout, frame}; a push that finds
// the FIFO full (with no pop in the same cycle) is dropped and flagged.
module macc_result_fifo
    import macc_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_drop
);

    localparam int PW = clog2(DEPTH);
    typedef logic [PW:0]   cnt_t;
    typedef logic [PW-1:0] ptr_t;
    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam ptr_t PTR_ONE  = ptr_t'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_count;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == CNT_ZERO);
    assign w_full    = (r_count == CNT_FULL);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_data    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/macc_frame_ctrl.sv
// Frame controller around a DSP48-style MACC: frames the sample stream into
// new_acc-delimited accumulations, flushes on disable and tags each result.
module macc_frame_ctrl
    import macc_frame_pkg::*;
#(
    parameter int DIN1_WIDTH  = 16,
    parameter int DIN2_WIDTH  = 16,
    parameter int DOUT_WIDTH  = 48,
    parameter int LEN_WIDTH   = 16,
    parameter int FRAME_WIDTH = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [LEN_WIDTH-1:0]   acc_len,
    input  logic [DIN1_WIDTH-1:0]  din1,
    input  logic [DIN2_WIDTH-1:0]  din2,
    input  logic                   din_valid,
    output logic [DIN1_WIDTH-1:0]  macc_din1,
    output logic [DIN2_WIDTH-1:0]  macc_din2,
    output logic                   macc_din_valid,
    output logic                   macc_new_acc,
    input  logic [DOUT_WIDTH-1:0]  macc_dout,
    input  logic                   macc_dout_valid,
    output logic [DOUT_WIDTH-1:0]  dout,
    output logic [FRAME_WIDTH-1:0] dout_frame,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overflow,
    output logic                   busy
);

    typedef logic [LEN_WIDTH-1:0]   len_t;
    typedef logic [FRAME_WIDTH-1:0] frame_t;
    typedef logic [DQ_IW:0]         dq_cnt_t;
    localparam len_t    LEN_ZERO   = len_t'(0);
    localparam len_t    LEN_ONE    = len_t'(1);
    localparam frame_t  FRAME_ONE  = frame_t'(1);
    localparam dq_cnt_t DQ_ZERO    = dq_cnt_t'(0);
    localparam dq_cnt_t DQ_ONE     = dq_cnt_t'(1);
    localparam dq_cnt_t DQ_FULL    = dq_cnt_t'(DQ_DEPTH);

    state_t  r_state;
    state_t  w_state_nxt;
    len_t    r_cnt;
    len_t    w_cnt_nxt;
    len_t    r_len;
    len_t    w_len_nxt;
    len_t    w_len_in;
    logic    w_fwd;
    logic    w_new;
    logic    w_flush;
    logic    w_from_idle;

    logic [DIN1_WIDTH-1:0] r_macc_din1;
    logic [DIN2_WIDTH-1:0] r_macc_din2;
    logic                  r_macc_din_valid;
    logic                  r_macc_new_acc;

    logic [DQ_DEPTH-1:0] r_dq;
    logic [DQ_DEPTH-1:0] w_dq_nxt;
    dq_cnt_t             r_dq_cnt;
    dq_cnt_t             w_dq_cnt_nxt;
    dq_cnt_t             w_dq_cnt_mid;
    logic                w_dq_pop;
    logic                w_issue;
    logic                w_discard;
    logic                w_res_push;

    frame_t r_res_frame;
    logic   r_overflow;
    logic   r_discard_pending;
    logic   r_busy;

    logic [DOUT_WIDTH+FRAME_WIDTH-1:0] w_fifo_wdata;
    logic [DOUT_WIDTH+FRAME_WIDTH-1:0] w_fifo_rdata;
    logic w_fifo_empty;
    logic w_fifo_pop;
    logic w_fifo_drop;

    assign w_len_in = (acc_len == LEN_ZERO) ? LEN_ONE : acc_len;

    // Next-state and frame sequencing decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_fwd       = 1'b0;
        w_new       = 1'b0;
        w_flush     = 1'b0;
        w_from_idle = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && din_valid) begin
                    w_fwd       = 1'b1;
                    w_new       = 1'b1;
                    w_from_idle = 1'b1;
                    w_len_nxt   = w_len_in;
                    w_cnt_nxt   = LEN_ONE;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                    if (din_valid) begin
                        w_fwd = 1'b1;
                        if (r_cnt == r_len) begin
                            w_new     = 1'b1;
                            w_cnt_nxt = LEN_ONE;
                            w_len_nxt = w_len_in;
                        end else begin
                            w_cnt_nxt = r_cnt + LEN_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end else if (r_cnt == r_len) begin
                    // Frame already complete: a sample now would open a new frame, so it is dropped.
                    w_state_nxt = ST_FLUSH;
                end else if (din_valid) begin
                    w_fwd       = 1'b1;
                    w_cnt_nxt   = r_cnt + LEN_ONE;
                    w_state_nxt = (r_cnt + LEN_ONE == r_len) ? ST_FLUSH : ST_DRAIN;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                w_flush     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, sample count and latched frame length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= LEN_ZERO;
            r_len   <= LEN_ZERO;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Registered MACC drive; FLUSH injects a zero sample that releases the last frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_macc_din1      <= '0;
            r_macc_din2      <= '0;
            r_macc_din_valid <= 1'b0;
            r_macc_new_acc   <= 1'b0;
        end else begin
            r_macc_din_valid <= w_fwd | w_flush;
            r_macc_new_acc   <= w_new | w_flush;
            if (w_flush) begin
                r_macc_din1 <= '0;
                r_macc_din2 <= '0;
            end else if (w_fwd) begin
                r_macc_din1 <= din1;
                r_macc_din2 <= din2;
            end else begin
                r_macc_din1 <= r_macc_din1;
                r_macc_din2 <= r_macc_din2;
            end
        end
    end

    // Each issued new_acc yields one MACC result in order; the queue remembers which to hide.
    assign w_issue    = w_new | w_flush;
    assign w_dq_pop   = macc_dout_valid & (r_dq_cnt != DQ_ZERO);
    assign w_discard  = macc_dout_valid & ((r_dq_cnt == DQ_ZERO) | r_dq[0]);
    assign w_res_push = macc_dout_valid & ~w_discard;

    // Discard-tag queue next state
    always_comb begin
        w_dq_nxt     = w_dq_pop ? (r_dq >> 1) : r_dq;
        w_dq_cnt_mid = w_dq_pop ? (r_dq_cnt - DQ_ONE) : r_dq_cnt;
        w_dq_cnt_nxt = w_dq_cnt_mid;
        if (w_issue && (w_dq_cnt_mid < DQ_FULL)) begin
            w_dq_nxt[w_dq_cnt_mid[DQ_IW-1:0]] = w_from_idle & r_discard_pending;
            w_dq_cnt_nxt                      = w_dq_cnt_mid + DQ_ONE;
        end else begin
            w_dq_cnt_nxt = w_dq_cnt_mid;
        end
    end

    // Result bookkeeping: discard tracking, frame tags and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq              <= '0;
            r_dq_cnt          <= DQ_ZERO;
            r_res_frame       <= '0;
            r_overflow        <= 1'b0;
            r_discard_pending <= 1'b1;
        end else begin
            r_dq     <= w_dq_nxt;
            r_dq_cnt <= w_dq_cnt_nxt;
            if (w_res_push) begin
                r_res_frame <= r_res_frame + FRAME_ONE;
            end else begin
                r_res_frame <= r_res_frame;
            end
            if (w_fifo_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
            if (w_flush) begin
                r_discard_pending <= 1'b1;
            end else if (w_from_idle) begin
                r_discard_pending <= 1'b0;
            end else begin
                r_discard_pending <= r_discard_pending;
            end
        end
    end

    assign w_fifo_wdata = {macc_dout, r_res_frame};
    assign w_fifo_pop   = dout_ready & ~w_fifo_empty;

    macc_result_fifo #(
        .DATA_WIDTH(DOUT_WIDTH + FRAME_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_res_push),
        .i_data (w_fifo_wdata),
        .i_pop  (w_fifo_pop),
        .o_data (w_fifo_rdata),
        .o_empty(w_fifo_empty),
        .o_drop (w_fifo_drop)
    );

    assign macc_din1      = r_macc_din1;
    assign macc_din2      = r_macc_din2;
    assign macc_din_valid = r_macc_din_valid;
    assign macc_new_acc   = r_macc_new_acc;
    assign dout           = w_fifo_rdata[DOUT_WIDTH+FRAME_WIDTH-1:FRAME_WIDTH];
    assign dout_frame     = w_fifo_rdata[FRAME_WIDTH-1:0];
    assign dout_valid     = ~w_fifo_empty;
    assign overflow       = r_overflow;
    assign busy           = r_busy;

endmodule
